// File: rtl/beaver32rv_trace_pkg.sv
// Shared types for the beaver32rv retire-trace buffer: entry layout and capture FSM states.
// Entry layout (MSB first) is {pc, rd, wdata, regwrite, taken}; the buffer packs vectors in this order.
package beaver32rv_trace_pkg;

    localparam int TRACE_XLEN = 32;

    typedef struct packed {
        logic [TRACE_XLEN-1:0] pc;
        logic [4:0]            rd;
        logic [TRACE_XLEN-1:0] wdata;
        logic                  regwrite;
        logic                  taken;
    } trace_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } trace_state_e;

endpackage

// File: rtl/beaver32rv_trace_fifo.sv
// DEPTH-entry trace storage; read data is combinational at rptr, a push is visible the next clock.
// Full: WRAP_MODE=0 drops the push, WRAP_MODE=1 overwrites the oldest; a same-cycle pop always makes room.
module beaver32rv_trace_fifo #(
    parameter int W         = 71,
    parameter int DEPTH     = 16,
    parameter int WRAP_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_clr,
    input  logic                       i_push,
    input  logic [W-1:0]               i_push_dat,
    input  logic                       i_pop_rdy,
    output logic                       o_rd_vld,
    output logic [W-1:0]               o_rd_dat,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic w_full;
    logic w_pop;
    logic w_wr;
    logic w_rd_adv;

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_pop    = (r_count != '0) && i_pop_rdy;
    // In wrap mode a push into a full buffer lands on the oldest slot, so rptr must step past it.
    assign w_wr     = i_push && (!w_full || w_pop || (WRAP_MODE != 0));
    assign w_rd_adv = w_pop || (i_push && w_full && (WRAP_MODE != 0));

    always_ff @(posedge clk) begin
        if (rst && w_wr) begin
            r_mem[r_wptr] <= i_push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (i_clr) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_rd_adv) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_wr, w_rd_adv})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (i_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_rd_vld   = (r_count != '0);
    assign o_rd_dat   = r_mem[r_rptr];
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/beaver32rv_trace_buffer.sv
// Retire-trace capture for beaver32rv over a RUN_CYCLES window (0 = unlimited); entries drain one clock after push via rd_valid/rd_ready in any state.
// Full buffer drops or overwrites per WRAP_MODE. Optional pc watchpoint that ends capture: BEAVER32RV_TRACE_WATCH_EN.
module beaver32rv_trace_buffer
    import beaver32rv_trace_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 16,
    parameter int RUN_CYCLES = 18,
    parameter int WRAP_MODE  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic                       stop,
    input  logic                       trace_valid,
    input  logic [XLEN-1:0]            trace_pc,
    input  logic [4:0]                 trace_rd,
    input  logic [XLEN-1:0]            trace_wdata,
    input  logic                       trace_regwrite,
    input  logic                       trace_taken,
    input  logic                       rd_ready,
`ifdef BEAVER32RV_TRACE_WATCH_EN
    input  logic                       watch_en,
    input  logic [XLEN-1:0]            watch_pc,
    output logic                       watch_hit,
`endif
    output logic                       rd_valid,
    output logic [2*XLEN+6:0]          rd_entry,
    output logic [1:0]                 state_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow
);

    localparam int EW  = 2*XLEN + 7;
    localparam int CCW = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

    trace_state_e   r_state;
    trace_state_e   w_state_nxt;
    logic [CCW-1:0] r_cycle_cnt;
    logic           w_clr;
    logic           w_push;
    logic           w_window_end;
    logic           w_watch_trig;
    logic [EW-1:0]  w_push_dat;

    assign w_clr      = arm && (r_state != CAPTURE);
    assign w_push     = (r_state == CAPTURE) && trace_valid;
    assign w_push_dat = {trace_pc, trace_rd, trace_wdata, trace_regwrite, trace_taken};

    generate
        if (RUN_CYCLES == 0) begin : g_unlimited
            assign w_window_end = 1'b0;
        end else begin : g_window
            assign w_window_end = (r_cycle_cnt == CCW'(RUN_CYCLES - 1));
        end
    endgenerate

`ifdef BEAVER32RV_TRACE_WATCH_EN
    logic r_watch_hit;

    assign w_watch_trig = w_push && watch_en && (trace_pc == watch_pc);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_watch_hit <= 1'b0;
        end else if (w_clr) begin
            r_watch_hit <= 1'b0;
        end else if (w_watch_trig) begin
            r_watch_hit <= 1'b1;
        end
    end

    assign watch_hit = r_watch_hit;
`else
    assign w_watch_trig = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The terminating cycle's push is still taken; the FSM only blocks pushes from the following clock.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: if (arm) w_state_nxt = CAPTURE;
            CAPTURE:    if (stop || w_window_end || w_watch_trig) w_state_nxt = DONE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cycle_cnt <= '0;
        end else if (w_clr) begin
            r_cycle_cnt <= '0;
        end else if (r_state == CAPTURE) begin
            r_cycle_cnt <= r_cycle_cnt + CCW'(1);
        end
    end

    beaver32rv_trace_fifo #(
        .W         (EW),
        .DEPTH     (DEPTH),
        .WRAP_MODE (WRAP_MODE)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_clr),
        .i_push     (w_push),
        .i_push_dat (w_push_dat),
        .i_pop_rdy  (rd_ready),
        .o_rd_vld   (rd_valid),
        .o_rd_dat   (rd_entry),
        .o_count    (count_o),
        .o_overflow (overflow)
    );

    assign state_o = r_state;

endmodule

// File: tb/tb_beaver32rv_trace_buffer.sv
// Bench: three instances (drop/18, wrap/18, drop/unlimited) share stimulus and are checked every cycle
// against a list-based model, plus literal checks for the directed scenarios.
module tb_beaver32rv_trace_buffer;
    import beaver32rv_trace_pkg::*;

    typedef logic [70:0] ent_t;

    logic        clk;
    logic        rst, arm, stop, trace_valid, trace_regwrite, trace_taken, rd_ready;
    logic [31:0] trace_pc, trace_wdata;
    logic [4:0]  trace_rd;
`ifdef BEAVER32RV_TRACE_WATCH_EN
    logic        watch_en;
    logic [31:0] watch_pc;
    logic        hit [3];
`endif

    logic        rdv [3];
    ent_t        rde [3];
    logic [1:0]  st  [3];
    logic [4:0]  cnt [3];
    logic        ovf [3];

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        beaver32rv_trace_buffer #(
            .XLEN       (32),
            .DEPTH      (16),
            .RUN_CYCLES ((k == 2) ? 0 : 18),
            .WRAP_MODE  ((k == 1) ? 1 : 0)
        ) u_dut (
            .clk            (clk),
            .rst            (rst),
            .arm            (arm),
            .stop           (stop),
            .trace_valid    (trace_valid),
            .trace_pc       (trace_pc),
            .trace_rd       (trace_rd),
            .trace_wdata    (trace_wdata),
            .trace_regwrite (trace_regwrite),
            .trace_taken    (trace_taken),
            .rd_ready       (rd_ready),
`ifdef BEAVER32RV_TRACE_WATCH_EN
            .watch_en       (watch_en),
            .watch_pc       (watch_pc),
            .watch_hit      (hit[k]),
`endif
            .rd_valid       (rdv[k]),
            .rd_entry       (rde[k]),
            .state_o        (st[k]),
            .count_o        (cnt[k]),
            .overflow       (ovf[k])
        );
    end

    // Model: each instance is an ordered list of held entries (index 0 = oldest).
    ent_t mb [3][16];
    int   msz     [3];
    int   m_state [3];
    int   m_cyc   [3];
    bit   m_ovf   [3];
    bit   m_hit   [3];

    function automatic bit wrap_of(input int k);
        return (k == 1);
    endfunction

    function automatic int run_of(input int k);
        return (k == 2) ? 0 : 18;
    endfunction

    function automatic logic [31:0] pc_of(input ent_t e);
        trace_entry_t t;
        t = e;
        return t.pc;
    endfunction

    task automatic q_pop(input int k);
        for (int j = 0; j < 15; j++) mb[k][j] = mb[k][j+1];
        msz[k] = msz[k] - 1;
    endtask

    task automatic q_push(input int k, input ent_t e);
        mb[k][msz[k]] = e;
        msz[k] = msz[k] + 1;
    endtask

    task automatic model_step(input int k);
        bit   pop;
        bit   trig;
        ent_t e;
        e = {trace_pc, trace_rd, trace_wdata, trace_regwrite, trace_taken};
        if (!rst) begin
            m_state[k] = 0; msz[k] = 0; m_cyc[k] = 0; m_ovf[k] = 0; m_hit[k] = 0;
        end else begin
            pop = (msz[k] != 0) && rd_ready;
            if (m_state[k] != 1 && arm) begin
                m_state[k] = 1; msz[k] = 0; m_cyc[k] = 0; m_ovf[k] = 0; m_hit[k] = 0;
            end else begin
                if (pop) q_pop(k);
                if (m_state[k] == 1) begin
                    trig = 0;
                    if (trace_valid) begin
`ifdef BEAVER32RV_TRACE_WATCH_EN
                        trig = watch_en && (trace_pc == watch_pc);
`endif
                        if (msz[k] == 16) begin
                            m_ovf[k] = 1;
                            if (wrap_of(k)) begin
                                q_pop(k);
                                q_push(k, e);
                            end
                        end else begin
                            q_push(k, e);
                        end
                        if (trig) m_hit[k] = 1;
                    end
                    if (stop || trig || (run_of(k) != 0 && m_cyc[k] == run_of(k) - 1)) m_state[k] = 2;
                    m_cyc[k] = m_cyc[k] + 1;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) model_step(k);
    end

    task automatic chk(input string nm, input int k, input logic [70:0] act, input logic [70:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, k, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                chk("rd_valid", k, 71'(rdv[k]), 71'(msz[k] != 0));
                chk("count", k, 71'(cnt[k]), 71'(msz[k]));
                chk("state", k, 71'(st[k]), 71'(m_state[k]));
                chk("overflow", k, 71'(ovf[k]), 71'(m_ovf[k]));
                if (msz[k] != 0) chk("rd_entry", k, rde[k], mb[k][0]);
`ifdef BEAVER32RV_TRACE_WATCH_EN
                chk("watch_hit", k, 71'(hit[k]), 71'(m_hit[k]));
`endif
            end
        end
    end

    task automatic push(input logic [31:0] pc);
        trace_valid    = 1'b1;
        trace_pc       = pc;
        trace_rd       = 5'($urandom);
        trace_wdata    = $urandom;
        trace_regwrite = 1'($urandom);
        trace_taken    = 1'($urandom);
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; arm = 1'b1; stop = 1'b0; rd_ready = 1'b0;
        trace_valid = 1'b0; trace_pc = '0; trace_rd = '0; trace_wdata = '0;
        trace_regwrite = 1'b0; trace_taken = 1'b0;
`ifdef BEAVER32RV_TRACE_WATCH_EN
        watch_en = 1'b0; watch_pc = '0;
`endif
        // Reset with arm held: reset wins.
        step; step;
        for (int k = 0; k < 3; k++) begin
            chk("rst_state", k, 71'(st[k]), 71'(0));
            chk("rst_count", k, 71'(cnt[k]), 71'(0));
            chk("rst_rd_valid", k, 71'(rdv[k]), 71'(0));
            chk("rst_overflow", k, 71'(ovf[k]), 71'(0));
        end
        chk_en = 1;
        rst = 1'b1; arm = 1'b0; step;

        // Window capture, every cycle valid.
        arm = 1'b1; step; arm = 1'b0;
        for (int i = 0; i < 18; i++) begin
            push(32'(4*i)); step;
        end
        trace_valid = 1'b0;
        chk("t2_count", 0, 71'(cnt[0]), 71'(16));
        chk("t2_overflow", 0, 71'(ovf[0]), 71'(1));
        chk("t2_state", 0, 71'(st[0]), 71'(2));
        chk("t3_count", 1, 71'(cnt[1]), 71'(16));
        chk("t3_overflow", 1, 71'(ovf[1]), 71'(1));
        chk("t2_unlimited_state", 2, 71'(st[2]), 71'(1));
        chk("model_size", 0, 71'(msz[0]), 71'(16));
        stop = 1'b1; step; stop = 1'b0;
        chk("stop_state", 2, 71'(st[2]), 71'(2));
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t2_drain_pc", 0, 71'(pc_of(rde[0])), 71'(4*i));
            chk("t3_drain_pc", 1, 71'(pc_of(rde[1])), 71'(8 + 4*i));
            step;
        end
        rd_ready = 1'b0;
        chk("t2_empty", 0, 71'(rdv[0]), 71'(0));
        chk("t3_empty", 1, 71'(rdv[1]), 71'(0));

        // Full buffer with push+pop in the same cycle (unlimited-window instance).
        arm = 1'b1; step; arm = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push(32'(4*i)); step;
        end
        rd_ready = 1'b1;
        for (int i = 16; i < 20; i++) begin
            push(32'(4*i)); step;
        end
        trace_valid = 1'b0; rd_ready = 1'b0; stop = 1'b1; step; stop = 1'b0;
        chk("t4_count", 2, 71'(cnt[2]), 71'(16));
        chk("t4_overflow", 2, 71'(ovf[2]), 71'(0));
        chk("t4_state", 2, 71'(st[2]), 71'(2));
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t4_drain_pc", 2, 71'(pc_of(rde[2])), 71'(32'h10 + 4*i));
            step;
        end
        rd_ready = 1'b0;

        // Reset mid-capture overrides arm/stop/push/pop.
        arm = 1'b1; step; arm = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(32'(4*i)); step;
        end
        rst = 1'b0; arm = 1'b1; stop = 1'b1; rd_ready = 1'b1; push(32'h100); step;
        rst = 1'b1; arm = 1'b0; stop = 1'b0; rd_ready = 1'b0; trace_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t5_state", k, 71'(st[k]), 71'(0));
            chk("t5_count", k, 71'(cnt[k]), 71'(0));
            chk("t5_rd_valid", k, 71'(rdv[k]), 71'(0));
        end
        arm = 1'b1; step; arm = 1'b0;
        rd_ready = 1'b1; push(32'h0); step;
        rd_ready = 1'b0; trace_valid = 1'b0;
        chk("t5_rearm_count", 0, 71'(cnt[0]), 71'(1));
        chk("t5_rearm_pc", 0, 71'(pc_of(rde[0])), 71'(0));
        stop = 1'b1; step; stop = 1'b0;

`ifdef BEAVER32RV_TRACE_WATCH_EN
        watch_en = 1'b1; watch_pc = 32'h20;
        arm = 1'b1; step; arm = 1'b0;
        for (int i = 0; i < 12; i++) begin
            push(32'(4*i)); step;
        end
        trace_valid = 1'b0; watch_en = 1'b0;
        chk("t6_count", 0, 71'(cnt[0]), 71'(9));
        chk("t6_state", 0, 71'(st[0]), 71'(2));
        chk("t6_hit", 0, 71'(hit[0]), 71'(1));
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) step;
        rd_ready = 1'b0;
        chk("t6_last_pc", 0, 71'(pc_of(rde[0])), 71'(32'h20));
        chk("t6_last_count", 0, 71'(cnt[0]), 71'(1));
`endif

        // Randomized traffic: model check runs every cycle.
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 63) != 0);
            arm      = ($urandom_range(0, 15) == 0);
            stop     = ($urandom_range(0, 31) == 0);
            rd_ready = 1'($urandom);
            if ($urandom_range(0, 3) != 0) push(32'(4*$urandom_range(0, 15)));
            else trace_valid = 1'b0;
`ifdef BEAVER32RV_TRACE_WATCH_EN
            watch_en = ($urandom_range(0, 7) == 0);
            watch_pc = 32'(4*$urandom_range(0, 15));
`endif
            step;
        end
        rst = 1'b1; arm = 1'b0; stop = 1'b0; rd_ready = 1'b0; trace_valid = 1'b0;
        step; step;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
